// File: rtl/lc3b_mem_arbiter_if.sv
// lc3b_mem_arbiter_if: core I/D ports and physical memory port bundle.
// slave = arbiter view, master = core/memory environment view.
interface lc3b_mem_arbiter_if;
    logic        i_read;
    logic        i_write;
    logic [15:0] i_address;
    logic [15:0] i_wdata;
    logic        i_resp;
    logic [15:0] i_rdata;

    logic        d_read;
    logic        d_write;
    logic [15:0] d_address;
    logic [15:0] d_wdata;
    logic [1:0]  d_byte_enable;
    logic        d_resp;
    logic [15:0] d_rdata;

    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic [1:0]  pmem_byte_enable;
    logic        pmem_resp;
    logic [15:0] pmem_rdata;

    modport slave (
        input  i_read, i_write, i_address, i_wdata,
        output i_resp, i_rdata,
        input  d_read, d_write, d_address, d_wdata, d_byte_enable,
        output d_resp, d_rdata,
        output pmem_read, pmem_write, pmem_address,
        output pmem_wdata, pmem_byte_enable,
        input  pmem_resp, pmem_rdata
    );

    modport master (
        output i_read, i_write, i_address, i_wdata,
        input  i_resp, i_rdata,
        output d_read, d_write, d_address, d_wdata, d_byte_enable,
        input  d_resp, d_rdata,
        input  pmem_read, pmem_write, pmem_address,
        input  pmem_wdata, pmem_byte_enable,
        output pmem_resp, pmem_rdata
    );
endinterface

// File: rtl/lc3b_mem_arbiter.sv
// lc3b_mem_arbiter: serialises LC-3b I and D ports onto one memory port.
// Optional perf counters enabled by defining LC3B_MEM_ARB_PERF_EN.
module lc3b_mem_arbiter (
    input  logic               clk,
    input  logic               reset,
    lc3b_mem_arbiter_if.slave  bus,
    output logic [15:0]        perf_i_count,
    output logic [15:0]        perf_d_count,
    output logic [15:0]        perf_busy_cycles
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE_D,
        ST_TURN,
        ST_SERVE_I,
        ST_RESP
    } state_e;

    state_e      state_q, state_d;
    logic        pend_d_q, pend_d_d;
    logic        pend_i_q, pend_i_d;

    logic        d_rd_q, d_rd_d;
    logic        d_wr_q, d_wr_d;
    logic [15:0] d_addr_q, d_addr_d;
    logic [15:0] d_wdata_q, d_wdata_d;
    logic [1:0]  d_be_q, d_be_d;

    logic        i_rd_q, i_rd_d;
    logic        i_wr_q, i_wr_d;
    logic [15:0] i_addr_q, i_addr_d;
    logic [15:0] i_wdata_q, i_wdata_d;

    logic [15:0] d_buf_q, d_buf_d;
    logic [15:0] i_buf_q, i_buf_d;

    logic        d_req;
    logic        i_req;

    assign d_req = bus.d_read | bus.d_write;
    assign i_req = bus.i_read | bus.i_write;

    // State, latched request fields and read buffers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pend_d_q  <= 1'b0;
            pend_i_q  <= 1'b0;
            d_rd_q    <= 1'b0;
            d_wr_q    <= 1'b0;
            d_addr_q  <= '0;
            d_wdata_q <= '0;
            d_be_q    <= '0;
            i_rd_q    <= 1'b0;
            i_wr_q    <= 1'b0;
            i_addr_q  <= '0;
            i_wdata_q <= '0;
            d_buf_q   <= '0;
            i_buf_q   <= '0;
        end else begin
            state_q   <= state_d;
            pend_d_q  <= pend_d_d;
            pend_i_q  <= pend_i_d;
            d_rd_q    <= d_rd_d;
            d_wr_q    <= d_wr_d;
            d_addr_q  <= d_addr_d;
            d_wdata_q <= d_wdata_d;
            d_be_q    <= d_be_d;
            i_rd_q    <= i_rd_d;
            i_wr_q    <= i_wr_d;
            i_addr_q  <= i_addr_d;
            i_wdata_q <= i_wdata_d;
            d_buf_q   <= d_buf_d;
            i_buf_q   <= i_buf_d;
        end
    end

    // Next state: latch requests in IDLE, D before I, joint response.
    always_comb begin
        state_d   = state_q;
        pend_d_d  = pend_d_q;
        pend_i_d  = pend_i_q;
        d_rd_d    = d_rd_q;
        d_wr_d    = d_wr_q;
        d_addr_d  = d_addr_q;
        d_wdata_d = d_wdata_q;
        d_be_d    = d_be_q;
        i_rd_d    = i_rd_q;
        i_wr_d    = i_wr_q;
        i_addr_d  = i_addr_q;
        i_wdata_d = i_wdata_q;
        d_buf_d   = d_buf_q;
        i_buf_d   = i_buf_q;

        unique case (state_q)
            ST_IDLE: begin
                pend_d_d = d_req;
                pend_i_d = i_req;
                if (d_req) begin
                    d_rd_d    = bus.d_read;
                    d_wr_d    = bus.d_write;
                    d_addr_d  = bus.d_address;
                    d_wdata_d = bus.d_wdata;
                    d_be_d    = bus.d_byte_enable;
                end
                if (i_req) begin
                    i_rd_d    = bus.i_read;
                    i_wr_d    = bus.i_write;
                    i_addr_d  = bus.i_address;
                    i_wdata_d = bus.i_wdata;
                end
                if (d_req) begin
                    state_d = ST_SERVE_D;
                end else if (i_req) begin
                    state_d = ST_SERVE_I;
                end
            end
            ST_SERVE_D: begin
                if (bus.pmem_resp) begin
                    // A combined read+write is a write; buffer keeps old data.
                    if (d_rd_q && !d_wr_q) begin
                        d_buf_d = bus.pmem_rdata;
                    end
                    state_d = pend_i_q ? ST_TURN : ST_RESP;
                end
            end
            ST_TURN: begin
                state_d = ST_SERVE_I;
            end
            ST_SERVE_I: begin
                if (bus.pmem_resp) begin
                    if (i_rd_q && !i_wr_q) begin
                        i_buf_d = bus.pmem_rdata;
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                pend_d_d = 1'b0;
                pend_i_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory-side drive and response pulses, decoded from registered state.
    always_comb begin
        bus.pmem_read        = 1'b0;
        bus.pmem_write       = 1'b0;
        bus.pmem_address     = '0;
        bus.pmem_wdata       = '0;
        bus.pmem_byte_enable = '0;
        bus.d_resp           = 1'b0;
        bus.i_resp           = 1'b0;

        unique case (state_q)
            ST_SERVE_D: begin
                bus.pmem_read        = d_rd_q & ~d_wr_q;
                bus.pmem_write       = d_wr_q;
                bus.pmem_address     = d_addr_q;
                bus.pmem_wdata       = d_wdata_q;
                bus.pmem_byte_enable = d_be_q;
            end
            ST_SERVE_I: begin
                bus.pmem_read        = i_rd_q & ~i_wr_q;
                bus.pmem_write       = i_wr_q;
                bus.pmem_address     = i_addr_q;
                bus.pmem_wdata       = i_wdata_q;
                bus.pmem_byte_enable = 2'b11;
            end
            ST_RESP: begin
                bus.d_resp = pend_d_q;
                bus.i_resp = pend_i_q;
            end
            default: begin
            end
        endcase
    end

    assign bus.d_rdata = d_buf_q;
    assign bus.i_rdata = i_buf_q;

`ifdef LC3B_MEM_ARB_PERF_EN
    logic [15:0] perf_i_q;
    logic [15:0] perf_d_q;
    logic [15:0] perf_busy_q;

    // Completed accesses per port and non-idle cycles, wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_i_q    <= '0;
            perf_d_q    <= '0;
            perf_busy_q <= '0;
        end else begin
            if (state_q == ST_SERVE_D && bus.pmem_resp) begin
                perf_d_q <= perf_d_q + 16'd1;
            end
            if (state_q == ST_SERVE_I && bus.pmem_resp) begin
                perf_i_q <= perf_i_q + 16'd1;
            end
            if (state_q != ST_IDLE) begin
                perf_busy_q <= perf_busy_q + 16'd1;
            end
        end
    end

    assign perf_i_count     = perf_i_q;
    assign perf_d_count     = perf_d_q;
    assign perf_busy_cycles = perf_busy_q;
`else
    assign perf_i_count     = 16'h0000;
    assign perf_d_count     = 16'h0000;
    assign perf_busy_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// tb_lc3b_mem_arbiter: vectors, directed sequences and a random
// scoreboard against a transaction-level model of the arbiter.
module tb_lc3b_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [15:0] perf_i_count;
    logic [15:0] perf_d_count;
    logic [15:0] perf_busy_cycles;

    lc3b_mem_arbiter_if bus();

    lc3b_mem_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .perf_i_count     (perf_i_count),
        .perf_d_count     (perf_d_count),
        .perf_busy_cycles (perf_busy_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
    } acc_t;

    typedef struct {
        logic        d_rd;
        logic        d_wr;
        logic        i_rd;
        logic        i_wr;
        logic [15:0] d_addr;
        logic [15:0] d_wdata;
        logic [1:0]  d_be;
        logic [15:0] i_addr;
        logic [15:0] i_wdata;
        int          ld;
        int          li;
    } req_t;

    typedef struct {
        req_t        r;
        int          cyc;
        logic        dr;
        logic        ir;
        logic [15:0] drd;
        logic [15:0] ird;
    } vec_t;

    acc_t        acc_log[$];
    int          lat_q[$];
    logic [15:0] mem [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];

    function automatic logic [15:0] dflt(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] o,
                                          input logic [15:0] n,
                                          input logic [1:0] be);
        logic [15:0] v;
        v[15:8] = be[1] ? n[15:8] : o[15:8];
        v[7:0]  = be[0] ? n[7:0]  : o[7:0];
        return v;
    endfunction

    function automatic logic [15:0] mrd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction

    function automatic logic [15:0] rrd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    task automatic chk1(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %b expected %b", n, a, e);
        end
    endtask

    task automatic chk16(input string n, input logic [15:0] a,
                         input logic [15:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic chki(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    // Physical memory: latency taken from lat_q at the start of each access.
    int   mcnt = 0;
    int   mlat = 1;
    acc_t macc;
    initial begin
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (bus.pmem_read === 1'b1 || bus.pmem_write === 1'b1) begin
                mcnt++;
                if (mcnt == 1) begin
                    mlat = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
                end
                if (mcnt == mlat) begin
                    macc.wr    = bus.pmem_write;
                    macc.addr  = bus.pmem_address;
                    macc.wdata = bus.pmem_wdata;
                    macc.be    = bus.pmem_byte_enable;
                    acc_log.push_back(macc);
                    bus.pmem_resp = 1'b1;
                    if (macc.wr) begin
                        mem[macc.addr] = merge(mrd(macc.addr),
                                               macc.wdata, macc.be);
                        bus.pmem_rdata = 16'h0000;
                    end else begin
                        bus.pmem_rdata = mrd(macc.addr);
                    end
                end else begin
                    bus.pmem_resp = 1'b0;
                end
            end else begin
                mcnt = 0;
                bus.pmem_resp = 1'b0;
            end
        end
    end

    task automatic idle_inputs();
        bus.i_read        = 1'b0;
        bus.i_write       = 1'b0;
        bus.i_address     = 16'h0000;
        bus.i_wdata       = 16'h0000;
        bus.d_read        = 1'b0;
        bus.d_write       = 1'b0;
        bus.d_address     = 16'h0000;
        bus.d_wdata       = 16'h0000;
        bus.d_byte_enable = 2'b00;
    endtask

    task automatic apply(input req_t r);
        bus.d_read        = r.d_rd;
        bus.d_write       = r.d_wr;
        bus.d_address     = r.d_addr;
        bus.d_wdata       = r.d_wdata;
        bus.d_byte_enable = r.d_be;
        bus.i_read        = r.i_rd;
        bus.i_write       = r.i_wr;
        bus.i_address     = r.i_addr;
        bus.i_wdata       = r.i_wdata;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        lat_q.delete();
    endtask

    // Present a request in an IDLE cycle, hold it until a response.
    task automatic run_txn(input req_t r, output int cyc,
                           output logic dr, output logic ir,
                           output logic [15:0] drd,
                           output logic [15:0] ird);
        cyc = -1;
        dr  = 1'b0;
        ir  = 1'b0;
        drd = 16'h0000;
        ird = 16'h0000;
        @(negedge clk);
        lat_q.delete();
        if (r.d_rd || r.d_wr) lat_q.push_back(r.ld);
        if (r.i_rd || r.i_wr) lat_q.push_back(r.li);
        apply(r);
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (bus.d_resp === 1'b1 || bus.i_resp === 1'b1) begin
                cyc = c;
                dr  = bus.d_resp;
                ir  = bus.i_resp;
                drd = bus.d_rdata;
                ird = bus.i_rdata;
                break;
            end
        end
        idle_inputs();
        chk1("txn_timeout", cyc > 0, 1'b1);
    endtask

    function automatic vec_t mkv(
        input logic dr_, input logic dw_, input logic ir_, input logic iw_,
        input logic [15:0] da, input logic [15:0] dwd, input logic [1:0] dbe,
        input logic [15:0] ia, input logic [15:0] iwd,
        input int ld, input int li, input int cyc,
        input logic edr, input logic eir,
        input logic [15:0] edrd, input logic [15:0] eird);
        vec_t v;
        v.r.d_rd = dr_;  v.r.d_wr = dw_;
        v.r.i_rd = ir_;  v.r.i_wr = iw_;
        v.r.d_addr = da; v.r.d_wdata = dwd; v.r.d_be = dbe;
        v.r.i_addr = ia; v.r.i_wdata = iwd;
        v.r.ld = ld;     v.r.li = li;
        v.cyc = cyc;     v.dr = edr; v.ir = eir;
        v.drd = edrd;    v.ird = eird;
        return v;
    endfunction

    vec_t        tbl[7];
    req_t        rq;
    int          cyc;
    logic        gdr, gir;
    logic [15:0] gdrd, gird;

    initial begin
        int   nresp, npulse, viol;
        logic prev_rd, since;
        logic [15:0] last_d, last_i;
        acc_t exp_acc[$];
        acc_t ea;
        int   ecyc;

        // Reset held with random inputs.
        reset = 1'b1;
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            bus.i_read        = 1'($urandom);
            bus.i_write       = 1'($urandom);
            bus.i_address     = 16'($urandom);
            bus.i_wdata       = 16'($urandom);
            bus.d_read        = 1'($urandom);
            bus.d_write       = 1'($urandom);
            bus.d_address     = 16'($urandom);
            bus.d_wdata       = 16'($urandom);
            bus.d_byte_enable = 2'($urandom);
            @(negedge clk);
            chk1("rst_pmem_read", bus.pmem_read, 1'b0);
            chk1("rst_pmem_write", bus.pmem_write, 1'b0);
        end
        chk1("rst_i_resp", bus.i_resp, 1'b0);
        chk1("rst_d_resp", bus.d_resp, 1'b0);
        chk16("rst_i_rdata", bus.i_rdata, 16'h0000);
        chk16("rst_d_rdata", bus.d_rdata, 16'h0000);
        chk16("rst_pmem_addr", bus.pmem_address, 16'h0000);
        chk16("rst_pmem_wdata", bus.pmem_wdata, 16'h0000);
        chk16("rst_pmem_be", 16'(bus.pmem_byte_enable), 16'h0000);
        chk16("rst_perf_i", perf_i_count, 16'h0000);
        chk16("rst_perf_d", perf_d_count, 16'h0000);
        chk16("rst_perf_busy", perf_busy_cycles, 16'h0000);
        idle_inputs();
        reset = 1'b0;

        // Single D read, latency 3.
        @(negedge clk);
        mem[16'h1234] = 16'hBEEF;
        lat_q.delete();
        lat_q.push_back(3);
        bus.d_read    = 1'b1;
        bus.d_address = 16'h1234;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c <= 3) begin
                chk16("drd_pmem_addr", bus.pmem_address, 16'h1234);
                chk1("drd_pmem_read", bus.pmem_read, 1'b1);
            end
            chk1("drd_d_resp", bus.d_resp, c == 4);
            chk1("drd_i_resp", bus.i_resp, 1'b0);
            if (c == 4) begin
                chk16("drd_d_rdata", bus.d_rdata, 16'hBEEF);
                idle_inputs();
            end
        end

        // Dual-port request, both latencies 1.
        @(negedge clk);
        mem[16'h0040] = 16'h1234;
        lat_q.delete();
        lat_q.push_back(1);
        lat_q.push_back(1);
        bus.i_read        = 1'b1;
        bus.i_address     = 16'h0040;
        bus.d_write       = 1'b1;
        bus.d_address     = 16'h2000;
        bus.d_wdata       = 16'h00A5;
        bus.d_byte_enable = 2'b01;
        @(negedge clk);
        chk1("dual_c1_write", bus.pmem_write, 1'b1);
        chk1("dual_c1_read", bus.pmem_read, 1'b0);
        chk16("dual_c1_addr", bus.pmem_address, 16'h2000);
        chk16("dual_c1_wdata", bus.pmem_wdata, 16'h00A5);
        chk16("dual_c1_be", 16'(bus.pmem_byte_enable), 16'h0001);
        @(negedge clk);
        chk1("dual_c2_read", bus.pmem_read, 1'b0);
        chk1("dual_c2_write", bus.pmem_write, 1'b0);
        @(negedge clk);
        chk1("dual_c3_read", bus.pmem_read, 1'b1);
        chk16("dual_c3_addr", bus.pmem_address, 16'h0040);
        chk16("dual_c3_be", 16'(bus.pmem_byte_enable), 16'h0003);
        chk1("dual_c3_iresp", bus.i_resp, 1'b0);
        @(negedge clk);
        chk1("dual_c4_iresp", bus.i_resp, 1'b1);
        chk1("dual_c4_dresp", bus.d_resp, 1'b1);
        chk16("dual_c4_irdata", bus.i_rdata, 16'h1234);
        idle_inputs();
        @(negedge clk);
        chk1("dual_c5_iresp", bus.i_resp, 1'b0);

        // Vector table.
        do_reset();
        mem[16'h0100] = 16'h1111;
        mem[16'h0200] = 16'h2222;
        mem[16'h0300] = 16'h3333;
        tbl[0] = mkv(1,0,0,0, 16'h0100,16'h0000,2'b11, 16'h0000,16'h0000,
                     2,1, 3, 1,0, 16'h1111,16'h0000);
        tbl[1] = mkv(0,0,1,0, 16'h0000,16'h0000,2'b00, 16'h0200,16'h0000,
                     1,1, 2, 0,1, 16'h1111,16'h2222);
        tbl[2] = mkv(0,1,0,0, 16'h0300,16'hABCD,2'b11, 16'h0000,16'h0000,
                     1,1, 2, 1,0, 16'h1111,16'h2222);
        tbl[3] = mkv(1,0,1,0, 16'h0300,16'h0000,2'b11, 16'h0100,16'h0000,
                     2,3, 7, 1,1, 16'hABCD,16'h1111);
        tbl[4] = mkv(1,1,1,0, 16'h0200,16'h00FF,2'b10, 16'h0200,16'h0000,
                     1,1, 4, 1,1, 16'hABCD,16'h0022);
        tbl[5] = mkv(0,0,1,1, 16'h0000,16'h0000,2'b00, 16'h0100,16'h5555,
                     1,4, 5, 0,1, 16'hABCD,16'h0022);
        tbl[6] = mkv(1,0,0,0, 16'h0100,16'h0000,2'b01, 16'h0000,16'h0000,
                     1,1, 2, 1,0, 16'h5555,16'h0022);
        for (int v = 0; v < 7; v++) begin
            run_txn(tbl[v].r, cyc, gdr, gir, gdrd, gird);
            chki($sformatf("vec%0d_cyc", v), cyc, tbl[v].cyc);
            chk1($sformatf("vec%0d_dresp", v), gdr, tbl[v].dr);
            chk1($sformatf("vec%0d_iresp", v), gir, tbl[v].ir);
            chk16($sformatf("vec%0d_drdata", v), gdrd, tbl[v].drd);
            chk16($sformatf("vec%0d_irdata", v), gird, tbl[v].ird);
        end

        // I read held across several transactions.
        @(negedge clk);
        lat_q.delete();
        repeat (10) lat_q.push_back(2);
        bus.i_read    = 1'b1;
        bus.i_address = 16'h0500;
        nresp = 0; npulse = 0; viol = 0;
        prev_rd = 1'b0; since = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (bus.pmem_read && !prev_rd) begin
                npulse++;
                since = 1'b1;
            end
            prev_rd = bus.pmem_read;
            if (bus.i_resp) begin
                nresp++;
                if (!since) viol++;
                since = 1'b0;
                if (nresp == 5) begin
                    chk16("held_irdata", bus.i_rdata, dflt(16'h0500));
                    idle_inputs();
                    break;
                end
            end
        end
        chki("held_nresp", nresp, 5);
        chki("held_npulse", npulse, 5);
        chki("held_violations", viol, 0);
        nresp = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.i_resp) nresp++;
        end
        chki("held_no_extra_resp", nresp, 0);

        // Reset while serving the I access.
        @(negedge clk);
        lat_q.delete();
        lat_q.push_back(1);
        lat_q.push_back(5);
        bus.d_read    = 1'b1;
        bus.d_address = 16'h0600;
        bus.i_read    = 1'b1;
        bus.i_address = 16'h0700;
        repeat (4) @(negedge clk);
        chk1("rsti_in_serve_i", bus.pmem_read, 1'b1);
        chk16("rsti_serve_addr", bus.pmem_address, 16'h0700);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        chk1("rsti_pmem_read", bus.pmem_read, 1'b0);
        chk1("rsti_pmem_write", bus.pmem_write, 1'b0);
        chk1("rsti_i_resp", bus.i_resp, 1'b0);
        reset = 1'b0;
        nresp = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.i_resp || bus.d_resp) nresp++;
        end
        chki("rsti_no_resp", nresp, 0);
        rq = mkv(1,0,0,0, 16'h0800,16'h0000,2'b11, 16'h0000,16'h0000,
                 2,1, 0, 0,0, 16'h0000,16'h0000).r;
        run_txn(rq, cyc, gdr, gir, gdrd, gird);
        chki("rsti_fresh_cyc", cyc, 3);
        chk1("rsti_fresh_dresp", gdr, 1'b1);
        chk1("rsti_fresh_iresp", gir, 1'b0);
        chk16("rsti_fresh_rdata", gdrd, dflt(16'h0800));

        // Random transactions against the transaction-level model.
        do_reset();
        last_d = 16'h0000;
        last_i = 16'h0000;
        for (int t = 0; t < 60; t++) begin
            int kind, dop, iop;
            kind = $urandom_range(1, 3);
            dop  = $urandom_range(0, 2);
            iop  = $urandom_range(0, 2);
            rq.d_rd    = kind[0] && (dop != 1);
            rq.d_wr    = kind[0] && (dop != 0);
            rq.i_rd    = kind[1] && (iop != 1);
            rq.i_wr    = kind[1] && (iop != 0);
            rq.d_addr  = 16'h3000 + 16'($urandom_range(0, 7));
            rq.i_addr  = 16'h3000 + 16'($urandom_range(0, 7));
            rq.d_wdata = 16'($urandom);
            rq.i_wdata = 16'($urandom);
            rq.d_be    = 2'($urandom);
            rq.ld      = $urandom_range(1, 4);
            rq.li      = $urandom_range(1, 4);

            exp_acc.delete();
            if (kind[0]) begin
                ea.wr = rq.d_wr; ea.addr = rq.d_addr;
                ea.wdata = rq.d_wdata; ea.be = rq.d_be;
                exp_acc.push_back(ea);
                if (rq.d_wr) begin
                    ref_mem[rq.d_addr] = merge(rrd(rq.d_addr),
                                               rq.d_wdata, rq.d_be);
                end else begin
                    last_d = rrd(rq.d_addr);
                end
            end
            if (kind[1]) begin
                ea.wr = rq.i_wr; ea.addr = rq.i_addr;
                ea.wdata = rq.i_wdata; ea.be = 2'b11;
                exp_acc.push_back(ea);
                if (rq.i_wr) begin
                    ref_mem[rq.i_addr] = rq.i_wdata;
                end else begin
                    last_i = rrd(rq.i_addr);
                end
            end
            if (kind == 3) ecyc = rq.ld + rq.li + 2;
            else if (kind == 1) ecyc = rq.ld + 1;
            else ecyc = rq.li + 1;

            acc_log.delete();
            run_txn(rq, cyc, gdr, gir, gdrd, gird);
            chki("rnd_cyc", cyc, ecyc);
            chk1("rnd_dresp", gdr, kind[0]);
            chk1("rnd_iresp", gir, kind[1]);
            chk16("rnd_drdata", gdrd, last_d);
            chk16("rnd_irdata", gird, last_i);
            chki("rnd_nacc", acc_log.size(), exp_acc.size());
            for (int a = 0; a < exp_acc.size() && a < acc_log.size(); a++) begin
                chk1("rnd_acc_wr", acc_log[a].wr, exp_acc[a].wr);
                chk16("rnd_acc_addr", acc_log[a].addr, exp_acc[a].addr);
                chk16("rnd_acc_be", 16'(acc_log[a].be), 16'(exp_acc[a].be));
                if (exp_acc[a].wr) begin
                    chk16("rnd_acc_wdata", acc_log[a].wdata, exp_acc[a].wdata);
                end
            end
        end

        // Two dual-port transactions from reset, then the counters.
        do_reset();
        rq = mkv(0,1,1,0, 16'h2000,16'h00A5,2'b01, 16'h0040,16'h0000,
                 1,1, 0, 0,0, 16'h0000,16'h0000).r;
        for (int k = 0; k < 2; k++) begin
            run_txn(rq, cyc, gdr, gir, gdrd, gird);
            chki("perf_dual_cyc", cyc, 4);
            chk1("perf_dual_joint", gdr & gir, 1'b1);
        end
        @(negedge clk);
`ifdef LC3B_MEM_ARB_PERF_EN
        chk16("perf_i_count", perf_i_count, 16'd2);
        chk16("perf_d_count", perf_d_count, 16'd2);
        chk16("perf_busy_cycles", perf_busy_cycles, 16'd8);
`else
        chk16("perf_i_count", perf_i_count, 16'd0);
        chk16("perf_d_count", perf_d_count, 16'd0);
        chk16("perf_busy_cycles", perf_busy_cycles, 16'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
